// File: rtl/fc_engine_rr_scheduler.sv
// fc_engine_rr_scheduler
// Time-shares one fully-connected layer engine among K requester streams.
// One requester owns the engine for a whole transaction: N input words are
// forwarded to the engine, then M result words are returned tagged with the
// owner's index. Ownership rotates round-robin between transactions.
//
// Handshake: every stream (req_*, eng_in_*, eng_out_*, resp_*) moves one beat
// on a rising clk edge where valid && ready are both high. valid never depends
// on ready. The datapath is purely combinational in both directions: zero
// latency and no buffering, so the engine sees the requester's handshake
// directly and the downstream sees the engine's output handshake directly.
module fc_engine_rr_scheduler #(
    parameter  int M   = 8,
    parameter  int N   = 8,
    parameter  int T   = 16,
    parameter  int K   = 4,
    localparam int IDW = (K > 1) ? $clog2(K) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [K-1:0]   req_valid,
    input  logic [K*T-1:0] req_data,
    output logic [K-1:0]   req_ready,
    output logic           eng_in_valid,
    input  logic           eng_in_ready,
    output logic [T-1:0]   eng_in_data,
    input  logic           eng_out_valid,
    output logic           eng_out_ready,
    input  logic [T-1:0]   eng_out_data,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [T-1:0]   resp_data,
    output logic [IDW-1:0] resp_id,
    output logic           busy,
    output logic           protocol_err
);

    localparam int NCW = (N > 1) ? $clog2(N) : 1;
    localparam int MCW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FEED    = 2'd1,
        S_COLLECT = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] last_grant;
    logic [NCW-1:0] in_cnt;
    logic [MCW-1:0] out_cnt;

    logic [IDW-1:0] pick;
    logic           found;
    logic           in_fire;
    logic           out_fire;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int j = 1; j <= K; j++) begin
            if (!found && req_valid[(int'(last_grant) + j) % K]) begin
                found = 1'b1;
                pick  = IDW'((int'(last_grant) + j) % K);
            end
        end
    end

    // Steer the owner's stream to the engine, or the engine's results out.
    always_comb begin
        req_ready     = '0;
        eng_in_valid  = 1'b0;
        eng_in_data   = '0;
        eng_out_ready = 1'b0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        case (state)
            S_FEED: begin
                eng_in_valid     = req_valid[grant];
                eng_in_data      = req_data[int'(grant)*T +: T];
                req_ready[grant] = eng_in_ready;
            end
            S_COLLECT: begin
                resp_valid    = eng_out_valid;
                resp_data     = eng_out_data;
                eng_out_ready = resp_ready;
            end
            default: ;
        endcase
    end

    assign in_fire  = eng_in_valid && eng_in_ready;
    assign out_fire = resp_valid && resp_ready;
    assign resp_id  = grant;
    assign busy     = (state != S_IDLE);

    // Transaction sequencing, beat counting and sticky error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            grant        <= '0;
            last_grant   <= IDW'(K - 1);
            in_cnt       <= '0;
            out_cnt      <= '0;
            protocol_err <= 1'b0;
        end else begin
            // The engine must only speak while results are being collected.
            if (state != S_COLLECT && eng_out_valid) begin
                protocol_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (in_fire) begin
                        if (in_cnt == NCW'(N - 1)) begin
                            in_cnt <= '0;
                            state  <= S_COLLECT;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (out_fire) begin
                        if (out_cnt == MCW'(M - 1)) begin
                            out_cnt    <= '0;
                            last_grant <= grant;
                            state      <= S_IDLE;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
